// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks the PC through IRAM, resolves jumps locally
// and hands every other opcode to the datapath over a registered valid/ready port.
module fetch_unit #(
  parameter logic [7:0] RESET_PC    = 8'd0,
  parameter logic [7:0] OP_NOP      = 8'd2,
  parameter logic [7:0] OP_JUMP     = 8'd29,
  parameter logic [7:0] OP_JMPZ     = 8'd32,
  parameter logic [7:0] OP_JMNZ     = 8'd37,
  parameter bit         HALT_ON_NOP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] iram_addr,
  input  logic [7:0] iram_data,
  output logic [7:0] instr,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       dp_idle,
  input  logic       z_flag,
  output logic [7:0] pc,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_OPFETCH,
    S_OPLATCH,
    S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] instr_q, instr_d;
  logic       instr_valid_q, instr_valid_d;
  logic       halted_q, halted_d;

  logic       lat_is_branch;
  logic       lat_is_halt;
  logic       br_taken;
  logic [7:0] pc_inc;

  assign pc_inc        = pc_q + 8'd1;
  assign lat_is_branch = (iram_data == OP_JUMP) || (iram_data == OP_JMPZ) ||
                         (iram_data == OP_JMNZ);
  assign lat_is_halt   = HALT_ON_NOP && (iram_data == OP_NOP);
  // ir_q holds the branch opcode while the operand byte is on iram_data
  assign br_taken      = (ir_q == OP_JUMP) ||
                         ((ir_q == OP_JMPZ) &&  z_flag) ||
                         ((ir_q == OP_JMNZ) && !z_flag);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ir_d          = ir_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    case (state_q)
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d = iram_data;
        if (lat_is_branch) begin
          pc_d    = pc_inc;
          state_d = S_OPFETCH;
        end else if (lat_is_halt) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          pc_d          = pc_inc;
          instr_d       = iram_data;
          instr_valid_d = 1'b1;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (instr_valid_q && instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_FETCH;
        end
      end
      S_OPFETCH: state_d = S_OPLATCH;
      S_OPLATCH: begin
        // z_flag is only trustworthy once all issued work has retired
        if (dp_idle) begin
          pc_d    = br_taken ? iram_data : pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        halted_d      = 1'b1;
        instr_valid_d = 1'b0;
      end
      default: begin
        state_d       = S_FETCH;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      ir_q          <= 8'd0;
      instr_q       <= 8'd0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign iram_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered-read IRAM model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] iram_addr;
  logic [7:0] iram_data = 8'd0;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready = 1'b1;
  logic       dp_idle = 1'b1;
  logic       z_flag = 1'b0;
  logic [7:0] pc;
  logic       halted;

  logic [7:0] rom [256];
  int         xfer_cnt;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) iram_data <= rom[iram_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          xfer_cnt <= 0;
    else if (instr_valid && instr_ready) xfer_cnt <= xfer_cnt + 1;
  end

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iram_addr  (iram_addr),
    .iram_data  (iram_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .dp_idle    (dp_idle),
    .z_flag     (z_flag),
    .pc         (pc),
    .halted     (halted)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold reset and fill IRAM with the halt opcode so stray fetches stop.
  task automatic start_test();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'd2;
    instr_ready = 1'b1;
    dp_idle     = 1'b1;
    z_flag      = 1'b0;
  endtask

  task automatic release_rst();
    tick(2);
    rst_n = 1'b1;
  endtask

  // Run a JMPZ/JMNZ at 103 (reached via a jump at 0) and check the next fetch address.
  task automatic branch_case(input string tag, input logic [7:0] op, input logic z,
                             input int exp_pc);
    start_test();
    rom[0] = 8'd29; rom[1] = 8'd103; rom[103] = op; rom[104] = 8'd120;
    z_flag = z;
    release_rst();
    tick(8);
    chk({tag, "_pc"}, pc, exp_pc);
    chk({tag, "_addr"}, iram_addr, exp_pc);
    chk({tag, "_novalid"}, xfer_cnt, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'd2;
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);

    // 1: back-to-back plain opcodes, 3 clks apart
    start_test();
    rom[0] = 8'd7; rom[1] = 8'd8;
    release_rst();
    tick(1);
    chk("t1_valid_c1", instr_valid, 0);
    tick(1);
    chk("t1_valid_c2", instr_valid, 1);
    chk("t1_instr0", instr, 7);
    chk("t1_pc0", pc, 1);
    tick(1);
    chk("t1_valid_fall", instr_valid, 0);
    tick(1);
    chk("t1_valid_gap", instr_valid, 0);
    tick(1);
    chk("t1_valid_2nd", instr_valid, 1);
    chk("t1_instr1", instr, 8);
    chk("t1_pc1", pc, 2);

    // 2: backpressure holds instr and pc stable; one transfer on ready
    start_test();
    rom[0] = 8'd19;
    instr_ready = 1'b0;
    release_rst();
    tick(2);
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", instr_valid, 1);
      chk("t2_hold_instr", instr, 19);
      chk("t2_hold_pc", pc, 1);
      tick(1);
    end
    chk("t2_no_xfer", xfer_cnt, 0);
    instr_ready = 1'b1;
    tick(1);
    chk("t2_valid_fall", instr_valid, 0);
    tick(6);
    chk("t2_one_xfer", xfer_cnt, 1);
    chk("t2_halt_after", halted, 1);

    // 3: two chained unconditional jumps issue nothing
    start_test();
    rom[0] = 8'd29; rom[1] = 8'd118;
    rom[118] = 8'd29; rom[119] = 8'd21; rom[21] = 8'd7;
    release_rst();
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      chk("t3_no_valid", instr_valid, 0);
      if (i == 4) chk("t3_pc_118", pc, 118);
    end
    tick(1);
    chk("t3_valid", instr_valid, 1);
    chk("t3_instr", instr, 7);
    chk("t3_pc", pc, 22);
    chk("t3_xfer0", xfer_cnt, 0);

    // 4: conditional branches both ways
    branch_case("t4_jmpz_z1", 8'd32, 1'b1, 120);
    branch_case("t4_jmpz_z0", 8'd32, 1'b0, 105);
    branch_case("t4_jmnz_z1", 8'd37, 1'b1, 105);
    branch_case("t4_jmnz_z0", 8'd37, 1'b0, 120);

    // 5: JMNZ waits for dp_idle, z sampled only when idle
    start_test();
    rom[0] = 8'd29; rom[1] = 8'd103; rom[103] = 8'd37; rom[104] = 8'd120;
    z_flag = 1'b1;
    release_rst();
    tick(6);
    chk("t5_opfetch_pc", pc, 104);
    dp_idle = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("t5_stall_pc", pc, 104);
      chk("t5_stall_valid", instr_valid, 0);
      z_flag = ~z_flag;
    end
    z_flag  = 1'b1;
    tick(1);
    chk("t5_still_stalled", pc, 104);
    z_flag  = 1'b0;
    dp_idle = 1'b1;
    tick(1);
    chk("t5_taken_pc", pc, 120);

    // 6a: halt on NOP, then reset clears halted
    start_test();
    rom[0] = 8'd29; rom[1] = 8'd120; rom[120] = 8'd2;
    release_rst();
    tick(6);
    chk("t6_halted", halted, 1);
    chk("t6_addr", iram_addr, 120);
    chk("t6_valid", instr_valid, 0);
    tick(10);
    chk("t6_still_halted", halted, 1);
    chk("t6_pc_frozen", pc, 120);
    chk("t6_no_xfer", xfer_cnt, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_halted", halted, 0);
    chk("t6_rst_pc", pc, 0);

    // 6b: pc wraps from 255 to 0
    start_test();
    rom[0] = 8'd29; rom[1] = 8'd255; rom[255] = 8'd7;
    release_rst();
    tick(6);
    chk("t6_wrap_valid", instr_valid, 1);
    chk("t6_wrap_instr", instr, 7);
    chk("t6_wrap_pc", pc, 0);

    // 6c: async reset in the middle of an issue
    start_test();
    rom[0] = 8'd19;
    instr_ready = 1'b0;
    release_rst();
    tick(3);
    chk("t6c_pre_valid", instr_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6c_valid", instr_valid, 0);
    chk("t6c_instr", instr, 0);
    chk("t6c_pc", pc, 0);
    chk("t6c_halted", halted, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
